// File: rtl/reg_wb_pkg.sv
// Shared types and sizes for the register-file write buffer.
// The entry layout is fixed to the 8x8 register file geometry.
package reg_wb_pkg;

  localparam int REG_AW   = 3;
  localparam int REG_DW   = 8;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_NULL = '{
    valid: 1'b0,
    addr:  {REG_AW{1'b0}},
    data:  {REG_DW{1'b0}}
  };

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first lookup of one read address among the pending buffer entries.
// Returns the data of the most recently queued matching entry, or zero on a miss.
module wb_fwd_match
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         rd_ptr,
  input  logic [CW-1:0]         count,
  input  logic [REG_AW-1:0]     rd_addr,
  output logic                  hit,
  output logic [REG_DW-1:0]     data
);

  logic [PW-1:0] idx_s;

  // Walk from the youngest occupied slot back to the head; first match wins.
  always_comb begin
    hit   = 1'b0;
    data  = {REG_DW{1'b0}};
    idx_s = {PW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx_s = rd_ptr + PW'(i);
      if (!hit && (CW'(i) < count) && entries[idx_s].valid &&
          (entries[idx_s].addr == rd_addr)) begin
        hit  = 1'b1;
        data = entries[idx_s].data;
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// In-order write buffer between multi-cycle producers and the register file's
// single write port, with read-address forwarding of pending entries.
module reg_write_buffer
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          WB_VALID,
  input  logic [AW-1:0] WB_ADDR,
  input  logic [DW-1:0] WB_DATA,
  output logic          WB_READY,
  input  logic          PORT_FREE,
  output logic          WRITE,
  output logic [AW-1:0] INADDRESS,
  output logic [DW-1:0] IN,
  input  logic [AW-1:0] RD1_ADDR,
  input  logic [AW-1:0] RD2_ADDR,
  output logic          FWD1_HIT,
  output logic [DW-1:0] FWD1_DATA,
  output logic          FWD2_HIT,
  output logic [DW-1:0] FWD2_DATA,
  output logic          BUSY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;

  wb_entry_t             head_s;
  logic                  enq_s;
  logic                  deq_s;

  // Handshake and occupancy flags; acceptance never depends on the port being free.
  always_comb begin
    WB_READY = (count_r != CNT_FULL);
    BUSY     = (count_r != CNT_ZERO);
    enq_s    = WB_VALID && WB_READY;
    deq_s    = WRITE;
  end

  // Present the head entry to the register file whenever the buffer holds data.
  always_comb begin
    head_s    = entries_r[rd_ptr_r];
    WRITE     = 1'b0;
    INADDRESS = {AW{1'b0}};
    IN        = {DW{1'b0}};
    if (count_r != CNT_ZERO) begin
      WRITE     = PORT_FREE;
      INADDRESS = head_s.addr;
      IN        = head_s.data;
    end else begin
      WRITE     = 1'b0;
      INADDRESS = {AW{1'b0}};
      IN        = {DW{1'b0}};
    end
  end

  // Entry storage and pointers; a dequeued slot is invalidated so it cannot forward.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= WB_ENTRY_NULL;
      end
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
    end else begin
      if (enq_s) begin
        entries_r[wr_ptr_r] <= '{valid: 1'b1, addr: WB_ADDR, data: WB_DATA};
        wr_ptr_r            <= wr_ptr_r + PTR_ONE;
      end
      if (deq_s) begin
        entries_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r                  <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy count; simultaneous enqueue and dequeue leave it unchanged.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd1 (
    .entries (entries_r),
    .rd_ptr  (rd_ptr_r),
    .count   (count_r),
    .rd_addr (RD1_ADDR),
    .hit     (FWD1_HIT),
    .data    (FWD1_DATA)
  );

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd2 (
    .entries (entries_r),
    .rd_ptr  (rd_ptr_r),
    .count   (count_r),
    .rd_addr (RD2_ADDR),
    .hit     (FWD2_HIT),
    .data    (FWD2_DATA)
  );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Scoreboard bench for reg_write_buffer: accepted writes are queued as expected
// drains; a negedge monitor checks every output against the queue model.
module tb_reg_write_buffer;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       WB_VALID;
  logic [2:0] WB_ADDR;
  logic [7:0] WB_DATA;
  logic       WB_READY;
  logic       PORT_FREE;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] RD1_ADDR;
  logic [2:0] RD2_ADDR;
  logic       FWD1_HIT;
  logic [7:0] FWD1_DATA;
  logic       FWD2_HIT;
  logic [7:0] FWD2_DATA;
  logic       BUSY;

  reg_write_buffer dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .WB_VALID  (WB_VALID),
    .WB_ADDR   (WB_ADDR),
    .WB_DATA   (WB_DATA),
    .WB_READY  (WB_READY),
    .PORT_FREE (PORT_FREE),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS),
    .IN        (IN),
    .RD1_ADDR  (RD1_ADDR),
    .RD2_ADDR  (RD2_ADDR),
    .FWD1_HIT  (FWD1_HIT),
    .FWD1_DATA (FWD1_DATA),
    .FWD2_HIT  (FWD2_HIT),
    .FWD2_DATA (FWD2_DATA),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int          test_cnt = 0;
  int          fail_cnt = 0;
  int          wr_seen  = 0;
  logic        mon_on   = 1'b0;
  logic        rand_on  = 1'b0;
  logic [10:0] exp_q[$];          // {addr, data}, oldest first
  logic [7:0]  ref_regs[8];
  logic [7:0]  dut_regs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Most recently queued write to ra, searched newest to oldest.
  function automatic void model_fwd(input logic [2:0] ra, output logic h, output logic [7:0] d);
    h = 1'b0;
    d = 8'h00;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (!h && exp_q[i][10:8] == ra) begin
        h = 1'b1;
        d = exp_q[i][7:0];
      end
    end
  endfunction

  // Offer one write; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] a, input logic [7:0] d);
    int  waited;
    logic done;
    waited = 0;
    done   = 1'b0;
    WB_VALID = 1'b1;
    WB_ADDR  = a;
    WB_DATA  = d;
    while (!done) begin
      @(negedge CLK);
      if (WB_READY === 1'b1) begin
        @(posedge CLK);
        exp_q.push_back({a, d});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("send_timeout", 32'(WB_READY), 32'd1);
          done = 1'b1;
        end
        @(posedge CLK);
      end
    end
    #1;
    WB_VALID = 1'b0;
  endtask

  task automatic wait_empty(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge CLK);
      if (BUSY === 1'b0) break;
    end
    check("drain_done", 32'(BUSY), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares all outputs with the queue model each cycle.
  initial begin
    int          n;
    logic        h;
    logic [7:0]  d;
    logic [10:0] head;
    forever begin
      @(negedge CLK);
      if (mon_on) begin
        if (RESETN === 1'b0) begin
          check("rst_ready", 32'(WB_READY), 32'd1);
          check("rst_write", 32'(WRITE), 32'd0);
          check("rst_inaddr", 32'(INADDRESS), 32'd0);
          check("rst_in", 32'(IN), 32'd0);
          check("rst_fwd1", 32'({FWD1_HIT, FWD1_DATA}), 32'd0);
          check("rst_fwd2", 32'({FWD2_HIT, FWD2_DATA}), 32'd0);
          check("rst_busy", 32'(BUSY), 32'd0);
        end else begin
          n = exp_q.size();
          check("wb_ready", 32'(WB_READY), 32'(n < 4));
          check("busy", 32'(BUSY), 32'(n != 0));
          check("write_en", 32'(WRITE), 32'((n != 0) && (PORT_FREE === 1'b1)));
          model_fwd(RD1_ADDR, h, d);
          check("fwd1_hit", 32'(FWD1_HIT), 32'(h));
          check("fwd1_data", 32'(FWD1_DATA), 32'(d));
          model_fwd(RD2_ADDR, h, d);
          check("fwd2_hit", 32'(FWD2_HIT), 32'(h));
          check("fwd2_data", 32'(FWD2_DATA), 32'(d));
          if (WRITE === 1'b1) begin
            wr_seen++;
            dut_regs[INADDRESS] = IN;
            if (n == 0) begin
              check("write_when_empty", 32'(WRITE), 32'd0);
            end else begin
              head = exp_q.pop_front();
              check("drain_addr", 32'(INADDRESS), 32'(head[10:8]));
              check("drain_data", 32'(IN), 32'(head[7:0]));
              ref_regs[head[10:8]] = head[7:0];
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < 8; i++) begin
      ref_regs[i] = 8'h00;
      dut_regs[i] = 8'h00;
    end
    RESETN = 1'b0; WB_VALID = 1'b0; WB_ADDR = 3'd0; WB_DATA = 8'h00;
    PORT_FREE = 1'b1; RD1_ADDR = 3'd0; RD2_ADDR = 3'd0;
    mon_on = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #2 RESETN = 1'b1;
    @(posedge CLK); #1;

    // Single write: drives the port in the next cycle, then the buffer empties.
    PORT_FREE = 1'b1;
    send(3'd3, 8'h5A);
    @(negedge CLK);
    check("t2_write", 32'(WRITE), 32'd1);
    check("t2_inaddr", 32'(INADDRESS), 32'd3);
    check("t2_in", 32'(IN), 32'h5A);
    @(negedge CLK);
    check("t2_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;

    // Fill while the port is taken; fifth write is held off.
    PORT_FREE = 1'b0;
    for (int i = 0; i < 4; i++) send(3'(i + 4), 8'(8'h30 + i));
    WB_VALID = 1'b1; WB_ADDR = 3'd1; WB_DATA = 8'hE5;
    repeat (3) begin
      @(negedge CLK);
      check("t3_full_ready", 32'(WB_READY), 32'd0);
      check("t3_full_write", 32'(WRITE), 32'd0);
    end
    @(posedge CLK); #1;
    PORT_FREE = 1'b1;
    w0 = wr_seen;
    send(3'd1, 8'hE5);
    wait_empty(20);
    check("t3_writes", 32'(wr_seen - w0), 32'd5);

    // Forwarding: youngest of two same-address writes, miss on the other port.
    PORT_FREE = 1'b0; RD1_ADDR = 3'd2; RD2_ADDR = 3'd5;
    send(3'd2, 8'h11);
    send(3'd2, 8'h22);
    @(negedge CLK);
    check("t4_fwd1_hit", 32'(FWD1_HIT), 32'd1);
    check("t4_fwd1_data", 32'(FWD1_DATA), 32'h22);
    check("t4_fwd2_hit", 32'(FWD2_HIT), 32'd0);
    @(posedge CLK); #1;
    PORT_FREE = 1'b1;
    wait_empty(20);

    // Full buffer with a continuous producer: one drain per cycle, pointers wrap.
    PORT_FREE = 1'b0;
    for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), 8'($urandom));
    PORT_FREE = 1'b1;
    w0 = wr_seen;
    for (int i = 0; i < 20; i++) send(3'($urandom_range(0, 7)), 8'($urandom));
    wait_empty(40);
    check("t5_writes", 32'(wr_seen - w0), 32'd24);

    // Mid-run reset with three pending entries: they must never be written.
    PORT_FREE = 1'b0;
    for (int i = 0; i < 3; i++) send(3'(i), 8'(8'hA0 + i));
    @(negedge CLK); #2 RESETN = 1'b0;
    exp_q.delete();
    w0 = wr_seen;
    repeat (2) @(negedge CLK);
    #2 RESETN = 1'b1;
    @(posedge CLK); #1;
    PORT_FREE = 1'b1;
    repeat (5) @(negedge CLK);
    check("t1_no_writes", 32'(wr_seen - w0), 32'd0);
    check("t1_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;

    // Random traffic against the register-file model.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge CLK); #1;
          PORT_FREE = ($urandom_range(0, 3) != 0);
          RD1_ADDR  = 3'($urandom_range(0, 7));
          RD2_ADDR  = 3'($urandom_range(0, 7));
        end
      end
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            @(posedge CLK); #1;
          end else begin
            send(3'($urandom_range(0, 7)), 8'($urandom));
          end
        end
        rand_on = 1'b0;
      end
    join
    @(posedge CLK); #1;
    PORT_FREE = 1'b1;
    wait_empty(20);
    for (int i = 0; i < 8; i++) check($sformatf("t6_reg%0d", i), 32'(dut_regs[i]), 32'(ref_regs[i]));

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
